mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/mem_access_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: control-bit layout,
// access sizes and FSM states.
package mem_access_stage_pkg;

  localparam int unsigned MS_WIDTH     = 6;
  localparam int unsigned MS_MEM_READ  = 5;
  localparam int unsigned MS_MEM_WRITE = 4;
  localparam int unsigned MS_SIZE_HI   = 3;
  localparam int unsigned MS_SIZE_LO   = 2;
  localparam int unsigned MS_UNSIGNED  = 1;
  localparam int unsigned MS_REG_WRITE = 0;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mas_state_e;

  // The reserved size never aligns, so it always ends as a bubble.
  function automatic logic is_aligned(input mem_size_e size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data memory and the core:
// store byte enables / replication and load lane select with extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic [1:0]         addr_lo,
  input  mem_size_e          size,
  input  logic               is_unsigned,
  input  logic [NB_DATA-1:0] store_data,
  input  logic [NB_DATA-1:0] rdata,
  output logic [3:0]         be,
  output logic [NB_DATA-1:0] wdata,
  output logic [NB_DATA-1:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'b0000;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = NB_DATA'({4{store_data[7:0]}});
        load_data = {{(NB_DATA-8){lane_b[7] & ~is_unsigned}}, lane_b};
      end
      SIZE_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata     = NB_DATA'({2{store_data[15:0]}});
        load_data = {{(NB_DATA-16){lane_h[15] & ~is_unsigned}}, lane_h};
      end
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses, waits out slow memory
// with an upstream stall, and registers the MEM/WB slot on the falling edge.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_REGWR = 5,
  parameter int unsigned NB_PC    = 7
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                en_pipeline_i,
  input  logic                valid_i,
  input  logic [NB_DATA-1:0]  alu_result_i,
  input  logic [NB_DATA-1:0]  data_wr_to_mem_i,
  input  logic [NB_REGWR-1:0] writeReg_i,
  input  logic [NB_PC-1:0]    pc_i,
  input  logic [MS_WIDTH-1:0] mem_signals_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [NB_DATA-1:0]  dmem_addr_o,
  output logic [NB_DATA-1:0]  dmem_wdata_o,
  output logic [3:0]          dmem_be_o,
  input  logic [NB_DATA-1:0]  dmem_rdata_i,
  input  logic                dmem_ready_i,
  output logic                stall_o,
  output logic                wb_valid_o,
  output logic                wb_reg_write_o,
  output logic [NB_DATA-1:0]  wb_data_o,
  output logic [NB_REGWR-1:0] wb_writeReg_o,
  output logic [NB_PC-1:0]    wb_pc_o,
  output logic                misalign_o
);

  mas_state_e          state_q;
  logic                done_q;
  logic [NB_DATA-1:0]  addr_q;
  logic [NB_DATA-1:0]  wdata_q;
  logic [MS_WIDTH-1:0] sig_q;
  logic [NB_REGWR-1:0] reg_q;
  logic [NB_PC-1:0]    pc_q;
  logic [NB_DATA-1:0]  rdata_q;

  logic                hold_sel;
  logic                valid_s;
  logic [NB_DATA-1:0]  addr_s;
  logic [NB_DATA-1:0]  wdata_s;
  logic [MS_WIDTH-1:0] sig_s;
  logic [NB_REGWR-1:0] reg_s;
  logic [NB_PC-1:0]    pc_s;
  logic [NB_DATA-1:0]  rdata_s;
  mem_size_e           size_s;
  logic                mem_read_s;
  logic                mem_write_s;
  logic                mem_op_s;
  logic                aligned_s;
  logic                idle_c;
  logic                wait_c;
  logic                issue_c;
  logic                bubble_c;
  logic                wb_load_c;
  logic [NB_DATA-1:0]  load_data_c;

  // While an access is outstanding or its result is parked, the latched slot
  // drives everything, so the request stays stable whatever upstream shows.
  assign hold_sel    = (state_q == ST_WAIT) | done_q;
  assign valid_s     = hold_sel | valid_i;
  assign addr_s      = hold_sel ? addr_q  : alu_result_i;
  assign wdata_s     = hold_sel ? wdata_q : data_wr_to_mem_i;
  assign sig_s       = hold_sel ? sig_q   : mem_signals_i;
  assign reg_s       = hold_sel ? reg_q   : writeReg_i;
  assign pc_s        = hold_sel ? pc_q    : pc_i;
  assign rdata_s     = done_q   ? rdata_q : dmem_rdata_i;

  assign size_s      = mem_size_e'(sig_s[MS_SIZE_HI:MS_SIZE_LO]);
  assign mem_read_s  = sig_s[MS_MEM_READ];
  assign mem_write_s = sig_s[MS_MEM_WRITE];
  assign mem_op_s    = mem_read_s | mem_write_s;
  assign aligned_s   = is_aligned(size_s, addr_s[1:0]);

  mem_lane_align #(
    .NB_DATA (NB_DATA)
  ) u_lane (
    .addr_lo     (addr_s[1:0]),
    .size        (size_s),
    .is_unsigned (sig_s[MS_UNSIGNED]),
    .store_data  (wdata_s),
    .rdata       (rdata_s),
    .be          (dmem_be_o),
    .wdata       (dmem_wdata_o),
    .load_data   (load_data_c)
  );

  // Request / stall decode; reset gates the request so it drops at once.
  assign idle_c   = (state_q == ST_IDLE);
  assign wait_c   = reset_n_i & (state_q == ST_WAIT);
  assign issue_c  = reset_n_i & en_pipeline_i & valid_i & idle_c & ~done_q
                  & mem_op_s & aligned_s;
  assign bubble_c = valid_s & mem_op_s & ~aligned_s;

  assign dmem_req_o  = issue_c | wait_c;
  assign dmem_we_o   = dmem_req_o & mem_write_s;
  assign dmem_addr_o = {addr_s[NB_DATA-1:2], 2'b00};
  assign stall_o     = dmem_req_o & ~dmem_ready_i;

  assign wb_load_c = en_pipeline_i
                   & ((idle_c & ~(issue_c & ~dmem_ready_i))
                    | ((state_q == ST_WAIT) & dmem_ready_i));

  always_ff @(negedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      sig_q          <= '0;
      reg_q          <= '0;
      pc_q           <= '0;
      rdata_q        <= '0;
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_data_o      <= '0;
      wb_writeReg_o  <= '0;
      wb_pc_o        <= '0;
      misalign_o     <= 1'b0;
    end else begin
      if (idle_c) begin
        if (issue_c && !dmem_ready_i) state_q <= ST_WAIT;
      end else if (dmem_ready_i) begin
        state_q <= ST_IDLE;
      end

      if (issue_c && !dmem_ready_i) begin
        addr_q  <= alu_result_i;
        wdata_q <= data_wr_to_mem_i;
        sig_q   <= mem_signals_i;
        reg_q   <= writeReg_i;
        pc_q    <= pc_i;
      end

      // Memory finished while the pipeline is frozen: park the read word.
      if ((state_q == ST_WAIT) && dmem_ready_i && !en_pipeline_i) begin
        done_q  <= 1'b1;
        rdata_q <= dmem_rdata_i;
      end else if (done_q && en_pipeline_i) begin
        done_q  <= 1'b0;
      end

      if (en_pipeline_i && idle_c && !done_q && bubble_c) misalign_o <= 1'b1;

      if (wb_load_c) begin
        wb_valid_o     <= valid_s & ~bubble_c;
        wb_reg_write_o <= valid_s & ~bubble_c & sig_s[MS_REG_WRITE];
        wb_data_o      <= (valid_s & mem_read_s & aligned_s) ? load_data_c : addr_s;
        wb_writeReg_o  <= reg_s;
        wb_pc_o        <= pc_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; state advances on the
// falling edge, so inputs are driven and outputs sampled around the rising edge.
module tb_mem_access_stage;

  localparam int unsigned NB_DATA  = 32;
  localparam int unsigned NB_REGWR = 5;
  localparam int unsigned NB_PC    = 7;

  logic                clock_i = 1'b0;
  logic                reset_n_i;
  logic                en_pipeline_i;
  logic                valid_i;
  logic [NB_DATA-1:0]  alu_result_i;
  logic [NB_DATA-1:0]  data_wr_to_mem_i;
  logic [NB_REGWR-1:0] writeReg_i;
  logic [NB_PC-1:0]    pc_i;
  logic [5:0]          mem_signals_i;
  logic                dmem_req_o;
  logic                dmem_we_o;
  logic [NB_DATA-1:0]  dmem_addr_o;
  logic [NB_DATA-1:0]  dmem_wdata_o;
  logic [3:0]          dmem_be_o;
  logic [NB_DATA-1:0]  dmem_rdata_i;
  logic                dmem_ready_i;
  logic                stall_o;
  logic                wb_valid_o;
  logic                wb_reg_write_o;
  logic [NB_DATA-1:0]  wb_data_o;
  logic [NB_REGWR-1:0] wb_writeReg_o;
  logic [NB_PC-1:0]    wb_pc_o;
  logic                misalign_o;

  int n_cmp = 0;
  int n_mis = 0;
  int stall_cnt;

  // mem_signals encodings: {rd, wr, size[1:0], unsigned, reg_write}
  localparam logic [5:0] SW_WORD  = 6'h18;
  localparam logic [5:0] SW_HALF  = 6'h14;
  localparam logic [5:0] SW_BYTE  = 6'h10;
  localparam logic [5:0] LB_S     = 6'h21;
  localparam logic [5:0] LB_U     = 6'h23;
  localparam logic [5:0] LH_S     = 6'h25;
  localparam logic [5:0] LW      = 6'h29;
  localparam logic [5:0] ALU_OP   = 6'h01;

  mem_access_stage #(
    .NB_DATA  (NB_DATA),
    .NB_REGWR (NB_REGWR),
    .NB_PC    (NB_PC)
  ) dut (
    .clock_i          (clock_i),
    .reset_n_i        (reset_n_i),
    .en_pipeline_i    (en_pipeline_i),
    .valid_i          (valid_i),
    .alu_result_i     (alu_result_i),
    .data_wr_to_mem_i (data_wr_to_mem_i),
    .writeReg_i       (writeReg_i),
    .pc_i             (pc_i),
    .mem_signals_i    (mem_signals_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_rdata_i     (dmem_rdata_i),
    .dmem_ready_i     (dmem_ready_i),
    .stall_o          (stall_o),
    .wb_valid_o       (wb_valid_o),
    .wb_reg_write_o   (wb_reg_write_o),
    .wb_data_o        (wb_data_o),
    .wb_writeReg_o    (wb_writeReg_o),
    .wb_pc_o          (wb_pc_o),
    .misalign_o       (misalign_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic vld, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [4:0] wr, input logic [6:0] pc,
                      input logic [5:0] sig, input logic [31:0] rd, input logic rdy);
    @(posedge clock_i);
    #1;
    en_pipeline_i    = en;
    valid_i          = vld;
    alu_result_i     = alu;
    data_wr_to_mem_i = wd;
    writeReg_i       = wr;
    pc_i             = pc;
    mem_signals_i    = sig;
    dmem_rdata_i     = rd;
    dmem_ready_i     = rdy;
    #1;
  endtask

  task automatic tick();
    @(negedge clock_i);
    #2;
  endtask

  initial begin
    reset_n_i = 1'b0;
    en_pipeline_i = 1'b0; valid_i = 1'b0; alu_result_i = '0; data_wr_to_mem_i = '0;
    writeReg_i = '0; pc_i = '0; mem_signals_i = '0; dmem_rdata_i = '0; dmem_ready_i = 1'b0;
    #2;
    chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'h0);
    chk("rst_req", 32'(dmem_req_o), 32'h0);
    @(posedge clock_i); #1 reset_n_i = 1'b1;

    // Store word, ready at once
    step(1, 1, 32'h10, 32'hDEADBEEF, 5'd0, 7'h01, SW_WORD, 32'h0, 1);
    chk("sw_req", 32'(dmem_req_o), 32'h1);
    chk("sw_we", 32'(dmem_we_o), 32'h1);
    chk("sw_be", 32'(dmem_be_o), 32'hF);
    chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
    chk("sw_addr", dmem_addr_o, 32'h10);
    chk("sw_stall", 32'(stall_o), 32'h0);
    tick();
    chk("sw_wb_valid", 32'(wb_valid_o), 32'h1);
    chk("sw_wb_regwr", 32'(wb_reg_write_o), 32'h0);
    chk("sw_wb_data", wb_data_o, 32'h10);
    chk("sw_wb_pc", 32'(wb_pc_o), 32'h01);

    // Half and byte stores: lane enables and replication
    step(1, 1, 32'h22, 32'h0000ABCD, 5'd0, 7'h02, SW_HALF, 32'h0, 1);
    chk("sh_be", 32'(dmem_be_o), 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
    chk("sh_addr", dmem_addr_o, 32'h20);
    tick();
    step(1, 1, 32'h11, 32'h0000005A, 5'd0, 7'h03, SW_BYTE, 32'h0, 1);
    chk("sb_be", 32'(dmem_be_o), 32'h2);
    chk("sb_wdata", dmem_wdata_o, 32'h5A5A5A5A);
    tick();

    // Byte loads, signed then unsigned
    step(1, 1, 32'h13, 32'h0, 5'd7, 7'h04, LB_S, 32'h80FF0011, 1);
    chk("lb_req", 32'(dmem_req_o), 32'h1);
    chk("lb_we", 32'(dmem_we_o), 32'h0);
    tick();
    chk("lbs_wb_data", wb_data_o, 32'hFFFFFF80);
    chk("lbs_wb_regwr", 32'(wb_reg_write_o), 32'h1);
    chk("lbs_wb_reg", 32'(wb_writeReg_o), 32'd7);
    step(1, 1, 32'h13, 32'h0, 5'd7, 7'h05, LB_U, 32'h80FF0011, 1);
    tick();
    chk("lbu_wb_data", wb_data_o, 32'h00000080);

    // Half load with three not-ready cycles; upstream inputs scrambled while waiting
    stall_cnt = 0;
    step(1, 1, 32'h22, 32'h0, 5'd9, 7'h22, LH_S, 32'h0, 0);
    chk("lh_req0", 32'(dmem_req_o), 32'h1);
    chk("lh_addr0", dmem_addr_o, 32'h20);
    stall_cnt += int'(stall_o);
    tick();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 7'h7F, SW_WORD, 32'h0, 0);
      chk("lh_req_hold", 32'(dmem_req_o), 32'h1);
      chk("lh_addr_hold", dmem_addr_o, 32'h20);
      chk("lh_we_hold", 32'(dmem_we_o), 32'h0);
      stall_cnt += int'(stall_o);
      tick();
    end
    step(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 7'h7F, SW_WORD, 32'h80011234, 1);
    chk("lh_req_done", 32'(dmem_req_o), 32'h1);
    chk("lh_stall_done", 32'(stall_o), 32'h0);
    chk("lh_wb_not_yet", wb_data_o, 32'h00000080);
    tick();
    chk("lh_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("lh_wb_data", wb_data_o, 32'hFFFF8001);
    chk("lh_wb_pc", 32'(wb_pc_o), 32'h22);
    chk("lh_wb_reg", 32'(wb_writeReg_o), 32'd9);

    // Misaligned word load becomes a bubble and sets the sticky flag
    step(1, 1, 32'h05, 32'h0, 5'd3, 7'h10, LW, 32'h0, 1);
    chk("mis_req", 32'(dmem_req_o), 32'h0);
    tick();
    chk("mis_flag", 32'(misalign_o), 32'h1);
    chk("mis_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("mis_wb_regwr", 32'(wb_reg_write_o), 32'h0);

    // Non-memory op forwards the ALU result; flag stays set
    step(1, 1, 32'h1234, 32'h0, 5'd4, 7'h30, ALU_OP, 32'h0, 0);
    chk("alu_req", 32'(dmem_req_o), 32'h0);
    tick();
    chk("alu_wb_data", wb_data_o, 32'h1234);
    chk("alu_wb_valid", 32'(wb_valid_o), 32'h1);
    chk("alu_misalign", 32'(misalign_o), 32'h1);

    // Pipeline disabled: valid store must not issue, MEM/WB holds
    step(0, 1, 32'h50, 32'h11112222, 5'd0, 7'h31, SW_WORD, 32'h0, 1);
    chk("dis_req", 32'(dmem_req_o), 32'h0);
    tick();
    chk("dis_wb_data", wb_data_o, 32'h1234);
    chk("dis_wb_pc", 32'(wb_pc_o), 32'h30);

    // Invalid slot: no request, bubble written
    step(1, 0, 32'h44, 32'h0, 5'd1, 7'h32, LW, 32'h0, 1);
    chk("inv_req", 32'(dmem_req_o), 32'h0);
    tick();
    chk("inv_wb_valid", 32'(wb_valid_o), 32'h0);

    // Access completes while disabled; result lands once re-enabled
    step(1, 1, 32'h40, 32'h0, 5'd6, 7'h40, LW, 32'h0, 0);
    chk("ew_stall", 32'(stall_o), 32'h1);
    tick();
    step(0, 1, 32'h40, 32'h0, 5'd6, 7'h40, LW, 32'hCAFEF00D, 1);
    chk("ew_req_dis", 32'(dmem_req_o), 32'h1);
    tick();
    chk("ew_wb_hold", wb_data_o, 32'h44);
    step(0, 1, 32'h40, 32'h0, 5'd6, 7'h40, LW, 32'h0, 0);
    chk("ew_no_reissue", 32'(dmem_req_o), 32'h0);
    tick();
    step(1, 1, 32'h40, 32'h0, 5'd6, 7'h40, LW, 32'h0, 0);
    chk("ew_req_en", 32'(dmem_req_o), 32'h0);
    chk("ew_stall_en", 32'(stall_o), 32'h0);
    tick();
    chk("ew_wb_data", wb_data_o, 32'hCAFEF00D);
    chk("ew_wb_valid", 32'(wb_valid_o), 32'h1);
    chk("ew_wb_pc", 32'(wb_pc_o), 32'h40);

    // Reset pulse during WAIT abandons the access
    step(1, 1, 32'h22, 32'h0, 5'd2, 7'h50, LH_S, 32'h0, 0);
    tick();
    @(posedge clock_i);
    #1 reset_n_i = 1'b0;
    #1;
    chk("rw_req", 32'(dmem_req_o), 32'h0);
    chk("rw_wb_valid", 32'(wb_valid_o), 32'h0);
    chk("rw_wb_data", wb_data_o, 32'h0);
    chk("rw_wb_pc", 32'(wb_pc_o), 32'h0);
    chk("rw_misalign", 32'(misalign_o), 32'h0);
    valid_i = 1'b0;
    #1 reset_n_i = 1'b1;
    step(1, 1, 32'h64, 32'h01020304, 5'd0, 7'h51, SW_WORD, 32'h0, 1);
    chk("rw_idle_we", 32'(dmem_we_o), 32'h1);
    chk("rw_idle_addr", dmem_addr_o, 32'h64);
    chk("rw_idle_stall", 32'(stall_o), 32'h0);
    tick();
    chk("rw_wb_after", wb_data_o, 32'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
